// File: rtl/smart_light_pkg.sv
// Shared types and default constants for the smart lighting sensor front end.
// Used by the front end, the lighting controller and the benches, so that all
// agree on the ambient state encoding and on the default thresholds and timings.
package smart_light_pkg;

  typedef enum logic {AMB_DAY, AMB_NIGHT} amb_state_t;

  localparam int DEF_ADC_W       = 8;
  localparam int DEF_DARK_TH     = 60;
  localparam int DEF_LIGHT_TH    = 90;
  localparam int DEF_DEB_CYCLES  = 16;
  localparam int DEF_MOTION_HOLD = 64;
  localparam int DEF_AMB_QUAL    = 4;

endpackage

// File: rtl/sensor_debounce.sv
// Push-button debouncer. A new level is accepted after DEB_CYCLES consecutive
// samples that differ from the current stable level. Any agreeing sample
// restarts the count. rise_pulse is high for exactly one cycle, the same cycle
// in which stable first reads 1.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   raw         button sample (1 = pressed), clk-synchronous
//   stable      debounced level
//   rise_pulse  one-cycle pulse on each accepted press
module sensor_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic rise_pulse
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      stable     <= 1'b0;
      cnt        <= '0;
      rise_pulse <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      if (raw != stable) begin
        // cnt never exceeds DEB_CYCLES-1, so it cannot wrap.
        if (cnt == CW'(DEB_CYCLES - 1)) begin
          stable     <= raw;
          cnt        <= '0;
          rise_pulse <= raw;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/smart_light_sensor_frontend.sv
// Sensor conditioning front end for the smart lighting controller.
//   - Two debounced wall buttons -> manual_on / manual_off one-cycle pulses
//     (off wins when both land in the same cycle).
//   - PIR motion stretched by a retriggerable MOTION_HOLD-cycle hold.
//   - Ambient ADC samples drive a day/night FSM with hysteresis: AMB_QUAL
//     consecutive qualifying valid samples are needed to switch state.
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   pir_raw, btn_on_raw, btn_off_raw    raw sensor / button inputs
//   amb_valid, amb_data[ADC_W]          ambient sample strobe and value
//   motion, light_level(1=night)        conditioned levels
//   manual_on, manual_off               one-cycle button pulses
// Build option: define SENSOR_SYNC_EN to pass every input through a 2-flop
// synchronizer (all latencies grow by 2 cycles). Undefined, inputs are
// assumed to be synchronous to clk.
module smart_light_sensor_frontend
  import smart_light_pkg::*;
#(
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int MOTION_HOLD = DEF_MOTION_HOLD,
  parameter int ADC_W       = DEF_ADC_W,
  parameter int DARK_TH     = DEF_DARK_TH,
  parameter int LIGHT_TH    = DEF_LIGHT_TH,
  parameter int AMB_QUAL    = DEF_AMB_QUAL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pir_raw,
  input  logic             btn_on_raw,
  input  logic             btn_off_raw,
  input  logic             amb_valid,
  input  logic [ADC_W-1:0] amb_data,
  output logic             motion,
  output logic             light_level,
  output logic             manual_on,
  output logic             manual_off
);

  if (DARK_TH >= LIGHT_TH) begin : g_bad_th
    $error("DARK_TH must be below LIGHT_TH");
  end
  if (DEB_CYCLES < 1 || AMB_QUAL < 1) begin : g_bad_cnt
    $error("DEB_CYCLES and AMB_QUAL must be at least 1");
  end

  localparam int HW = (MOTION_HOLD > 0) ? $clog2(MOTION_HOLD + 1) : 1;
  localparam int QW = $clog2(AMB_QUAL + 1);
  localparam int SW = ADC_W + 4;

  // ---- input conditioning ----
  logic             pir_s, on_s, off_s, av_s;
  logic [ADC_W-1:0] ad_s;

`ifdef SENSOR_SYNC_EN
  logic [1:0][SW-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= {pir_raw, btn_on_raw, btn_off_raw, amb_valid, amb_data};
      sync_q[1] <= sync_q[0];
    end
  end

  assign {pir_s, on_s, off_s, av_s, ad_s} = sync_q[1];
`else
  assign {pir_s, on_s, off_s, av_s, ad_s} =
    SW'({pir_raw, btn_on_raw, btn_off_raw, amb_valid, amb_data});
`endif

  // ---- buttons: [0] = on, [1] = off ----
  logic [1:0] btn_raw, btn_rise;
  logic [1:0] btn_level_unused;  // debounced levels are not consumed here

  assign btn_raw = {off_s, on_s};

  for (genvar i = 0; i < 2; i++) begin : g_btn
    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk        (clk),
      .reset      (reset),
      .raw        (btn_raw[i]),
      .stable     (btn_level_unused[i]),
      .rise_pulse (btn_rise[i])
    );
  end

  // Pulses come straight from debouncer flops; the gate only resolves a tie.
  assign manual_off = btn_rise[1];
  assign manual_on  = btn_rise[0] & ~btn_rise[1];

  // ---- motion stretch ----
  logic [HW-1:0] hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold   <= '0;
      motion <= 1'b0;
    end else begin
      if (pir_s)             hold <= HW'(MOTION_HOLD);
      else if (hold != '0)   hold <= hold - HW'(1);
      motion <= pir_s | (hold != '0);
    end
  end

  // ---- ambient day/night FSM ----
  amb_state_t    amb_state;
  logic [QW-1:0] qual;
  logic          amb_hit;

  // A sample qualifies if it argues for leaving the current state.
  always_comb begin
    amb_hit = 1'b0;
    if (amb_state == AMB_DAY) amb_hit = (ad_s < ADC_W'(DARK_TH));
    else                      amb_hit = (ad_s > ADC_W'(LIGHT_TH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      amb_state   <= AMB_DAY;
      qual        <= '0;
      light_level <= 1'b0;
    end else if (av_s) begin
      if (amb_hit) begin
        if (qual == QW'(AMB_QUAL - 1)) begin
          amb_state   <= (amb_state == AMB_DAY) ? AMB_NIGHT : AMB_DAY;
          light_level <= (amb_state == AMB_DAY);
          qual        <= '0;
        end else begin
          qual <= qual + QW'(1);
        end
      end else begin
        qual <= '0;
      end
    end
  end

endmodule

// File: tb/tb_smart_light_sensor_frontend.sv
// Bench for smart_light_sensor_frontend with DEB_CYCLES=4, MOTION_HOLD=8,
// AMB_QUAL=3, DARK_TH=60, LIGHT_TH=90. Directed scenarios plus a randomized
// run against a window/history-based reference model.
// Cycle convention: inputs for cycle c are driven just after posedge c; the
// outputs seen at that moment are the cycle-c outputs.
module tb_smart_light_sensor_frontend;

  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int QUAL = 3;
  localparam int DTH  = 60;
  localparam int LTH  = 90;
  localparam int RN   = 600;

  logic       clk = 1'b0;
  logic       reset, pir_raw, btn_on_raw, btn_off_raw, amb_valid;
  logic [7:0] amb_data;
  logic       motion, light_level, manual_on, manual_off;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  smart_light_sensor_frontend #(
    .DEB_CYCLES(DEB), .MOTION_HOLD(HOLD), .ADC_W(8),
    .DARK_TH(DTH), .LIGHT_TH(LTH), .AMB_QUAL(QUAL)
  ) dut (
    .clk(clk), .reset(reset), .pir_raw(pir_raw), .btn_on_raw(btn_on_raw),
    .btn_off_raw(btn_off_raw), .amb_valid(amb_valid), .amb_data(amb_data),
    .motion(motion), .light_level(light_level),
    .manual_on(manual_on), .manual_off(manual_off)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; pir_raw = 1'b0; btn_on_raw = 1'b0; btn_off_raw = 1'b0;
    amb_valid = 1'b0; amb_data = 8'd0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; pir_raw = 1'b1; btn_on_raw = 1'b1; btn_off_raw = 1'b1;
    amb_valid = 1'b1; amb_data = 8'd0;
    repeat (6) tick();
    chk_cnt++; if (motion !== 1'b0) $display("FAIL reset motion=%b exp=0", motion); else pass_cnt++;
    chk_cnt++; if (light_level !== 1'b0) $display("FAIL reset light_level=%b exp=0", light_level); else pass_cnt++;
    chk_cnt++; if (manual_on !== 1'b0) $display("FAIL reset manual_on=%b exp=0", manual_on); else pass_cnt++;
    chk_cnt++; if (manual_off !== 1'b0) $display("FAIL reset manual_off=%b exp=0", manual_off); else pass_cnt++;
  endtask

  task automatic test_btn_hold();
    do_reset();
    for (int c = 0; c < 40; c++) begin
      btn_on_raw = (c >= 10 && c < 30);
      chk_cnt++; if (manual_on !== (c == 14)) $display("FAIL btn_hold c=%0d manual_on=%b exp=%b", c, manual_on, c == 14); else pass_cnt++;
      chk_cnt++; if (manual_off !== 1'b0) $display("FAIL btn_hold c=%0d manual_off=%b exp=0", c, manual_off); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_bounce();
    bit seq [7] = '{1, 1, 0, 1, 1, 1, 1};
    do_reset();
    for (int c = 0; c < 16; c++) begin
      btn_off_raw = (c < 7) ? seq[c] : 1'b1;
      chk_cnt++; if (manual_off !== (c == 7)) $display("FAIL bounce c=%0d manual_off=%b exp=%b", c, manual_off, c == 7); else pass_cnt++;
      chk_cnt++; if (manual_on !== 1'b0) $display("FAIL bounce c=%0d manual_on=%b exp=0", c, manual_on); else pass_cnt++;
      tick();
    end
    btn_off_raw = 1'b0;
  endtask

  task automatic test_both();
    do_reset();
    for (int c = 0; c < 14; c++) begin
      btn_on_raw = 1'b1; btn_off_raw = 1'b1;
      chk_cnt++; if (manual_off !== (c == 4)) $display("FAIL both c=%0d manual_off=%b exp=%b", c, manual_off, c == 4); else pass_cnt++;
      chk_cnt++; if (manual_on !== 1'b0) $display("FAIL both c=%0d manual_on=%b exp=0", c, manual_on); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_motion(input bit retrig);
    bit exp;
    do_reset();
    for (int c = 0; c < 28; c++) begin
      pir_raw = (c == 5 || c == 6 || (retrig && c == 12));
      exp = (c >= 6 && c <= (retrig ? 21 : 15));
      chk_cnt++; if (motion !== exp) $display("FAIL motion rt=%0d c=%0d motion=%b exp=%b", retrig, c, motion, exp); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_ambient(input bit gaps);
    int samp [12] = '{50, 50, 70, 50, 50, 50, 95, 95, 80, 95, 95, 95};
    int st;
    bit exp;
    st = gaps ? 2 : 1;
    do_reset();
    for (int c = 0; c < 12 * st + 4; c++) begin
      if (c % st == 0 && c / st < 12) begin
        amb_valid = 1'b1; amb_data = 8'(samp[c / st]);
      end else begin
        amb_valid = 1'b0; amb_data = 8'($urandom_range(0, 255));
      end
      exp = (c > 5 * st && c <= 11 * st);
      chk_cnt++; if (light_level !== exp) $display("FAIL ambient gaps=%0d c=%0d light_level=%b exp=%b", gaps, c, light_level, exp); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 16; c++) begin
      pir_raw    = (c == 0);
      btn_on_raw = (c >= 2 && c <= 4);
      amb_valid  = (c < 3);
      amb_data   = 8'd30;
      reset      = (c == 4);
      if (c == 4) begin
        chk_cnt++; if (motion !== 1'b1) $display("FAIL rst_mid pre motion=%b exp=1", motion); else pass_cnt++;
        chk_cnt++; if (light_level !== 1'b1) $display("FAIL rst_mid pre light_level=%b exp=1", light_level); else pass_cnt++;
      end
      if (c >= 5) begin
        chk_cnt++; if (motion !== 1'b0) $display("FAIL rst_mid c=%0d motion=%b exp=0", c, motion); else pass_cnt++;
        chk_cnt++; if (light_level !== 1'b0) $display("FAIL rst_mid c=%0d light_level=%b exp=0", c, light_level); else pass_cnt++;
        chk_cnt++; if (manual_on !== 1'b0) $display("FAIL rst_mid c=%0d manual_on=%b exp=0", c, manual_on); else pass_cnt++;
        chk_cnt++; if (manual_off !== 1'b0) $display("FAIL rst_mid c=%0d manual_off=%b exp=0", c, manual_off); else pass_cnt++;
      end
      tick();
    end
    reset = 1'b0;
  endtask

  // Reference: a button level flips once the last DEB samples taken since the
  // previous flip all disagree with it; motion is high when any pir sample lies
  // in the previous HOLD+1 cycles; day/night flips after QUAL consecutive
  // qualifying valid samples counted since the last flip.
  task automatic test_random();
    bit pir_h [RN];
    bit on_h [RN];
    bit off_h [RN];
    bit e_on [RN+1];
    bit e_off [RN+1];
    bit e_lvl [RN+1];
    bit s_on, s_off, night, flip_on, flip_off, exp_m, q;
    int l_on, l_off, run;
    do_reset();
    s_on = 0; s_off = 0; night = 0; run = 0; l_on = 0; l_off = 0;
    e_on[0] = 0; e_off[0] = 0; e_lvl[0] = 0;
    for (int c = 0; c < RN; c++) begin
      if ($urandom_range(5) == 0) btn_on_raw = ~btn_on_raw;
      if ($urandom_range(5) == 0) btn_off_raw = ~btn_off_raw;
      pir_raw   = ($urandom_range(11) == 0);
      amb_valid = ($urandom_range(2) != 0);
      case ($urandom_range(3))
        0: amb_data = 8'($urandom_range(0, 59));
        1: amb_data = 8'($urandom_range(60, 90));
        2: amb_data = 8'($urandom_range(91, 255));
        default: amb_data = ($urandom_range(1) == 0) ? (($urandom_range(1) == 0) ? 8'd59 : 8'd60)
                                                     : (($urandom_range(1) == 0) ? 8'd90 : 8'd91);
      endcase
      pir_h[c] = pir_raw; on_h[c] = btn_on_raw; off_h[c] = btn_off_raw;

      exp_m = 0;
      for (int p = c - 1; p >= 0 && p >= c - 1 - HOLD; p--) if (pir_h[p]) exp_m = 1;
      chk_cnt++; if (motion !== exp_m) $display("FAIL rand c=%0d motion=%b exp=%b", c, motion, exp_m); else pass_cnt++;
      chk_cnt++; if (manual_on !== e_on[c]) $display("FAIL rand c=%0d manual_on=%b exp=%b", c, manual_on, e_on[c]); else pass_cnt++;
      chk_cnt++; if (manual_off !== e_off[c]) $display("FAIL rand c=%0d manual_off=%b exp=%b", c, manual_off, e_off[c]); else pass_cnt++;
      chk_cnt++; if (light_level !== e_lvl[c]) $display("FAIL rand c=%0d light_level=%b exp=%b", c, light_level, e_lvl[c]); else pass_cnt++;

      flip_on = (c - DEB + 1 >= l_on);
      for (int k = c - DEB + 1; k <= c && flip_on; k++) if (k < 0 || on_h[k] == s_on) flip_on = 0;
      flip_off = (c - DEB + 1 >= l_off);
      for (int k = c - DEB + 1; k <= c && flip_off; k++) if (k < 0 || off_h[k] == s_off) flip_off = 0;
      if (flip_on)  begin s_on  = ~s_on;  l_on  = c + 1; end
      if (flip_off) begin s_off = ~s_off; l_off = c + 1; end
      e_off[c+1] = flip_off && s_off;
      e_on[c+1]  = flip_on && s_on && !(flip_off && s_off);

      if (amb_valid) begin
        q = night ? (int'(amb_data) > LTH) : (int'(amb_data) < DTH);
        run = q ? run + 1 : 0;
        if (run == QUAL) begin night = ~night; run = 0; end
      end
      e_lvl[c+1] = night;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_btn_hold();
    test_bounce();
    test_both();
    test_motion(1'b0);
    test_motion(1'b1);
    test_ambient(1'b0);
    test_ambient(1'b1);
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
